ej32_byte_wr: RTL and testbench

//  Memory-write serializer for eJ32 store ops (istore/iastore/sastore/bastore, put).

---
 rtl/ej32_pkg.sv | 19 +
 rtl/ej32_byte_wr.sv | 110 +++++++++++
 tb/tb_ej32_byte_wr.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ej32_pkg.sv
// Shared eJ32 definitions: byte-writer FSM states and store-size encodings.
// The control FSM uses the same st_n encoding.
package ej32_pkg;

    typedef enum logic [1:0] {
        wIDLE = 2'd0,
        wWR   = 2'd1,
        wDONE = 2'd2
    } wr_state_t;

    localparam logic [2:0] ST_BYTE  = 3'd1;
    localparam logic [2:0] ST_SHORT = 3'd2;
    localparam logic [2:0] ST_WORD  = 3'd4;

    function automatic logic st_n_legal(input logic [2:0] n);
        return (n == ST_BYTE) || (n == ST_SHORT) || (n == ST_WORD);
    endfunction

endpackage

// File: rtl/ej32_byte_wr.sv
// eJ32 store serializer: writes a latched 1/2/4-byte word onto the 8-bit memory bus.
// Define EJ32_BYTE_WR_LE_EN for little-endian byte order (default is big-endian, JVM order).
module ej32_byte_wr
    import ej32_pkg::*;
#(
    parameter int DSZ = 32,
    parameter int ASZ = 17
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           st_req,
    input  logic [2:0]     st_n,
    input  logic [ASZ-1:0] st_addr,
    input  logic [DSZ-1:0] st_data,
    input  logic           mem_rdy,
    output logic           mem_we,
    output logic [ASZ-1:0] mem_a,
    output logic [7:0]     mem_d,
    output logic           busy,
    output logic           done,
    output logic           err
);

    wr_state_t      state;
    logic [ASZ-1:0] base;
    logic [DSZ-1:0] data;
    logic [2:0]     cnt;
    logic [1:0]     idx;
    logic           err_q;
    logic           last;
    logic [1:0]     lane;

    function automatic logic [7:0] byte_lane(input logic [31:0] d, input logic [1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        return b;
    endfunction

    assign last = ({1'b0, idx} == (cnt - 3'd1));

    always_comb begin
`ifdef EJ32_BYTE_WR_LE_EN
        lane = idx;
`else
        lane = 2'(cnt - 3'd1 - {1'b0, idx});
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= wIDLE;
            base  <= '0;
            data  <= '0;
            cnt   <= '0;
            idx   <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                wIDLE: begin
                    if (st_req) begin
                        if (st_n_legal(st_n)) begin
                            base  <= st_addr;
                            data  <= st_data;
                            cnt   <= st_n;
                            idx   <= '0;
                            state <= wWR;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                wWR: begin
                    if (mem_rdy) begin
                        if (last) state <= wDONE;
                        else      idx   <= idx + 2'd1;
                    end
                end
                wDONE:   state <= wIDLE;
                default: state <= wIDLE;
            endcase
        end
    end

    // Outputs decode straight from state so an async reset drops mem_we in the same cycle.
    always_comb begin
        mem_we = 1'b0;
        mem_a  = '0;
        mem_d  = '0;
        busy   = 1'b0;
        done   = 1'b0;
        err    = err_q;
        case (state)
            wWR: begin
                mem_we = 1'b1;
                busy   = 1'b1;
                mem_a  = base + {{(ASZ-2){1'b0}}, idx};
                mem_d  = byte_lane(data[31:0], lane);
            end
            wDONE:   done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ej32_byte_wr.sv
// Self-checking bench for ej32_byte_wr: directed stores with a write scoreboard.
// Honours EJ32_BYTE_WR_LE_EN for the expected byte order.
module tb_ej32_byte_wr;

    localparam int DSZ = 32;
    localparam int ASZ = 17;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           st_req = 1'b0;
    logic [2:0]     st_n = '0;
    logic [ASZ-1:0] st_addr = '0;
    logic [DSZ-1:0] st_data = '0;
    logic           mem_rdy = 1'b1;
    logic           mem_we;
    logic [ASZ-1:0] mem_a;
    logic [7:0]     mem_d;
    logic           busy;
    logic           done;
    logic           err;

    int vectors = 0;
    int miscompares = 0;
    logic [ASZ+7:0] expq[$];

    ej32_byte_wr #(.DSZ(DSZ), .ASZ(ASZ)) dut (
        .clk(clk), .rst(rst), .st_req(st_req), .st_n(st_n), .st_addr(st_addr),
        .st_data(st_data), .mem_rdy(mem_rdy), .mem_we(mem_we), .mem_a(mem_a),
        .mem_d(mem_d), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_store(input logic [2:0] n, input logic [ASZ-1:0] addr, input logic [31:0] d);
        for (int k = 0; k < int'(n); k++) begin
            int sh;
`ifdef EJ32_BYTE_WR_LE_EN
            sh = 8 * k;
`else
            sh = 8 * (int'(n) - 1 - k);
`endif
            expq.push_back({ASZ'(addr + ASZ'(k)), 8'(d >> sh)});
        end
    endtask

    // Scoreboard write check on the current cycle, then advance one clock.
    task automatic tick();
        if (mem_we) begin
            if (expq.size() == 0) begin
                chk("unexpected_write", 32'(mem_we), 32'd0);
            end else begin
                chk("wr_byte", {7'b0, mem_a, mem_d}, {7'b0, expq[0]});
                if (mem_rdy) void'(expq.pop_front());
            end
        end
        chk("done_err_excl", 32'(done & err), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic status(input string tag, input logic b, input logic d, input logic e);
        chk({tag, "_busy"}, 32'(busy), 32'(b));
        chk({tag, "_done"}, 32'(done), 32'(d));
        chk({tag, "_err"},  32'(err),  32'(e));
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_a", 32'(mem_a), 32'd0);
        chk("rst_d", 32'(mem_d), 32'd0);
        status("rst", 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        // 1: word store, big-endian bytes 12,34,56,78 at 0x100..0x103
        st_req = 1'b1; st_n = 3'd4; st_addr = 17'h00100; st_data = 32'h12345678;
        push_store(3'd4, 17'h00100, 32'h12345678);
        tick();
        st_req = 1'b0; st_addr = 17'h0ABCD; st_data = 32'hDEADBEEF;
        for (int c = 1; c <= 4; c++) begin
            status("t1_wr", 1'b1, 1'b0, 1'b0);
            tick();
        end
        status("t1_done", 1'b0, 1'b1, 1'b0);
        chk("t1_done_we", 32'(mem_we), 32'd0);
        chk("t1_drained", 32'(expq.size()), 32'd0);
        tick();
        status("t1_idle", 1'b0, 1'b0, 1'b0);

        // 2: short store wrapping the address space
        st_req = 1'b1; st_n = 3'd2; st_addr = 17'h1FFFF; st_data = 32'hAABBCCDD;
        push_store(3'd2, 17'h1FFFF, 32'hAABBCCDD);
        tick();
        st_req = 1'b0;
        status("t2_c1", 1'b1, 1'b0, 1'b0);
        chk("t2_a1", 32'(mem_a), 32'h1FFFF);
        tick();
        chk("t2_a2", 32'(mem_a), 32'h00000);
        tick();
        status("t2_done", 1'b0, 1'b1, 1'b0);
        chk("t2_drained", 32'(expq.size()), 32'd0);
        tick();

        // 3: byte store with mem_rdy stalled for three cycles
        st_req = 1'b1; st_n = 3'd1; st_addr = 17'h00042; st_data = 32'h000000A5;
        push_store(3'd1, 17'h00042, 32'h000000A5);
        tick();
        st_req = 1'b0; mem_rdy = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            status("t3_stall", 1'b1, 1'b0, 1'b0);
            chk("t3_we", 32'(mem_we), 32'd1);
            chk("t3_a", 32'(mem_a), 32'h00042);
            chk("t3_d", 32'(mem_d), 32'h000000A5);
            tick();
        end
        mem_rdy = 1'b1;
        status("t3_c4", 1'b1, 1'b0, 1'b0);
        tick();
        status("t3_done", 1'b0, 1'b1, 1'b0);
        chk("t3_drained", 32'(expq.size()), 32'd0);
        tick();

        // 4: illegal sizes raise a single err pulse each and never write
        for (int i = 0; i < 2; i++) begin
            st_req = 1'b1; st_n = (i == 0) ? 3'd3 : 3'd0; st_addr = 17'h00200; st_data = 32'h11223344;
            tick();
            st_req = 1'b0;
            status("t4_err", 1'b0, 1'b0, 1'b1);
            chk("t4_we", 32'(mem_we), 32'd0);
            tick();
            status("t4_clear", 1'b0, 1'b0, 1'b0);
            chk("t4_we2", 32'(mem_we), 32'd0);
        end

        // 5: st_req held high; second store only accepted back in IDLE
        st_req = 1'b1; st_n = 3'd4; st_addr = 17'h00300; st_data = 32'hCAFEF00D;
        push_store(3'd4, 17'h00300, 32'hCAFEF00D);
        tick();
        for (int c = 1; c <= 4; c++) begin
            status("t5_wr", 1'b1, 1'b0, 1'b0);
            tick();
        end
        status("t5_done", 1'b0, 1'b1, 1'b0);
        chk("t5_one_store", 32'(expq.size()), 32'd0);
        tick();
        status("t5_idle6", 1'b0, 1'b0, 1'b0);
        chk("t5_we6", 32'(mem_we), 32'd0);
        push_store(3'd4, 17'h00300, 32'hCAFEF00D);
        tick();
        st_req = 1'b0;
        for (int c = 7; c <= 10; c++) begin
            status("t5_wr2", 1'b1, 1'b0, 1'b0);
            tick();
        end
        status("t5_done2", 1'b0, 1'b1, 1'b0);
        chk("t5_drained", 32'(expq.size()), 32'd0);
        tick();

        // 6: reset after two of four bytes aborts the store
        st_req = 1'b1; st_n = 3'd4; st_addr = 17'h00400; st_data = 32'h89ABCDEF;
        push_store(3'd4, 17'h00400, 32'h89ABCDEF);
        tick();
        st_req = 1'b0;
        tick();
        tick();
        chk("t6_pre_we", 32'(mem_we), 32'd1);
        chk("t6_left", 32'(expq.size()), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_we", 32'(mem_we), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        expq.delete();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            status("t6_after", 1'b0, 1'b0, 1'b0);
            chk("t6_no_we", 32'(mem_we), 32'd0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
